ssb_arbiter: RTL and testbench

- Parametrised shared-system-bus interconnect for the super system.
- Arbitrates NrHosts request/grant hosts (Ibex instr, Ibex data, debug SBA, future DMA) onto one shared bus.
- Decodes the address to one of NrDevices fixed-latency devices and routes the one-cycle-later response back to the granted host.
- Adds selectable round-robin arbitration and error responses for unmapped addresses.

---
 rtl/ssb_arbiter.sv | 131 +++++++++++++
 tb/tb_ssb_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ssb_arbiter.sv
// Shared system bus interconnect: arbitrates several request/grant hosts onto
// one device bus, decodes the address to a fixed-latency device and routes the
// one-cycle-later response back to the host that was granted.
module ssb_arbiter #(
  parameter int                    NrHosts       = 3,
  parameter int                    NrDevices     = 2,
  parameter bit                    ArbRoundRobin = 1'b1,
  parameter logic [NrDevices*32-1:0] DevStart    = {32'h1a110000, 32'h00000000},
  parameter logic [NrDevices*32-1:0] DevMask     = {32'h0000ffff, 32'h0000ffff}
) (
  input  logic                    clk_sys_i,
  input  logic                    rst_sys_ni,
  input  logic [NrHosts-1:0]      host_req_i,
  input  logic [NrHosts*32-1:0]   host_addr_i,
  input  logic [NrHosts-1:0]      host_we_i,
  input  logic [NrHosts*4-1:0]    host_be_i,
  input  logic [NrHosts*32-1:0]   host_wdata_i,
  output logic [NrHosts-1:0]      host_gnt_o,
  output logic [NrHosts-1:0]      host_rvalid_o,
  output logic [NrHosts-1:0]      host_err_o,
  output logic [31:0]             host_rdata_o,
  output logic [NrDevices-1:0]    dev_req_o,
  output logic [31:0]             dev_addr_o,
  output logic                    dev_we_o,
  output logic [3:0]              dev_be_o,
  output logic [31:0]             dev_wdata_o,
  input  logic [NrDevices*32-1:0] dev_rdata_i
);

  localparam int IdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;

  logic [IdxW-1:0]      last_q, last_d;
  logic [NrHosts-1:0]   gnt_host_q, gnt_host_d;
  logic [NrDevices-1:0] hit_dev_q, hit_dev_d;
  logic                 miss_q, miss_d;

  logic [NrHosts-1:0]   upper_mask;
  logic [NrHosts-1:0]   req_upper;
  logic [NrHosts-1:0]   req_pick;
  logic [NrHosts-1:0]   gnt;
  logic                 any_gnt;
  logic [NrDevices-1:0] hit;
  logic [NrDevices-1:0] hit_first;

  // Hosts strictly above the last winner get first pick in round-robin mode
  for (genvar gi = 0; gi < NrHosts; gi++) begin : g_mask
    assign upper_mask[gi] = (IdxW'(gi) > last_q);
  end

  assign req_upper = host_req_i & upper_mask;

  // Round-robin searches above last_q first and wraps to the bottom; fixed
  // priority always searches from host 0. Lowest set bit of the chosen set wins.
  always_comb begin
    req_pick = host_req_i;
    if (ArbRoundRobin && (|req_upper)) begin
      req_pick = req_upper;
    end
  end

  assign gnt        = req_pick & (~req_pick + NrHosts'(1));
  assign any_gnt    = |gnt;
  assign host_gnt_o = gnt;

  // Encode the one-hot grant into an index for the round-robin pointer
  always_comb begin
    last_d = '0;
    for (int h = 0; h < NrHosts; h++) begin
      last_d |= IdxW'(h) & {IdxW{gnt[h]}};
    end
  end

  // Drive the shared device bus from the granted host; all zero when idle
  always_comb begin
    dev_addr_o  = '0;
    dev_we_o    = 1'b0;
    dev_be_o    = '0;
    dev_wdata_o = '0;
    for (int h = 0; h < NrHosts; h++) begin
      dev_addr_o  |= host_addr_i[h*32 +: 32]  & {32{gnt[h]}};
      dev_we_o    |= host_we_i[h]             & gnt[h];
      dev_be_o    |= host_be_i[h*4 +: 4]      & {4{gnt[h]}};
      dev_wdata_o |= host_wdata_i[h*32 +: 32] & {32{gnt[h]}};
    end
  end

  // Address decode per device window
  for (genvar gi = 0; gi < NrDevices; gi++) begin : g_decode
    assign hit[gi] = ((dev_addr_o & ~DevMask[gi*32 +: 32]) == DevStart[gi*32 +: 32]);
  end

  // Overlapping windows resolve to the lowest device index
  assign hit_first = hit & (~hit + NrDevices'(1));
  assign dev_req_o = any_gnt ? hit_first : '0;

  // Response bookkeeping captured on the grant cycle
  always_comb begin
    gnt_host_d = gnt;
    hit_dev_d  = dev_req_o;
    miss_d     = any_gnt & ~(|hit);
  end

  // Response-select registers and round-robin pointer
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      gnt_host_q <= '0;
      hit_dev_q  <= '0;
      miss_q     <= 1'b0;
      last_q     <= IdxW'(NrHosts - 1);
    end else begin
      gnt_host_q <= gnt_host_d;
      hit_dev_q  <= hit_dev_d;
      miss_q     <= miss_d;
      if (any_gnt) begin
        last_q <= last_d;
      end
    end
  end

  // Return path: read data of the device hit last cycle, zero on a miss
  always_comb begin
    host_rdata_o = '0;
    for (int d = 0; d < NrDevices; d++) begin
      host_rdata_o |= dev_rdata_i[d*32 +: 32] & {32{hit_dev_q[d]}};
    end
  end

  assign host_rvalid_o = gnt_host_q;
  assign host_err_o    = gnt_host_q & {NrHosts{miss_q}};

endmodule

// File: tb/tb_ssb_arbiter.sv
// Directed bench for ssb_arbiter: a round-robin instance checked cycle by
// cycle against a hand-computed vector table, a fixed-priority instance
// checked on grants, plus a reset-during-response sequence.
module tb_ssb_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [31:0] a0, a1, a2;

  localparam logic [11:0] HOST_BE    = 12'h421;
  localparam logic [31:0] WDATA0     = 32'hA0A0A0A0;
  localparam logic [31:0] WDATA1     = 32'hB1B1B1B1;
  localparam logic [31:0] WDATA2     = 32'hC2C2C2C2;

  logic [2:0]  rr_gnt, rr_rvalid, rr_err;
  logic [31:0] rr_rdata;
  logic [1:0]  rr_dreq;
  logic [31:0] rr_daddr, rr_dwdata;
  logic        rr_dwe;
  logic [3:0]  rr_dbe;

  logic [2:0]  fx_gnt, fx_rvalid, fx_err;
  logic [31:0] fx_rdata;
  logic [1:0]  fx_dreq;
  logic [31:0] fx_daddr, fx_dwdata;
  logic        fx_dwe;
  logic [3:0]  fx_dbe;

  logic [31:0] rd0_q, rd1_q;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ssb_arbiter #(.NrHosts(3), .NrDevices(2), .ArbRoundRobin(1'b1)) u_rr (
    .clk_sys_i    (clk),
    .rst_sys_ni   (rst_n),
    .host_req_i   (req),
    .host_addr_i  ({a2, a1, a0}),
    .host_we_i    (we),
    .host_be_i    (HOST_BE),
    .host_wdata_i ({WDATA2, WDATA1, WDATA0}),
    .host_gnt_o   (rr_gnt),
    .host_rvalid_o(rr_rvalid),
    .host_err_o   (rr_err),
    .host_rdata_o (rr_rdata),
    .dev_req_o    (rr_dreq),
    .dev_addr_o   (rr_daddr),
    .dev_we_o     (rr_dwe),
    .dev_be_o     (rr_dbe),
    .dev_wdata_o  (rr_dwdata),
    .dev_rdata_i  ({rd1_q, rd0_q})
  );

  ssb_arbiter #(.NrHosts(3), .NrDevices(2), .ArbRoundRobin(1'b0)) u_fix (
    .clk_sys_i    (clk),
    .rst_sys_ni   (rst_n),
    .host_req_i   (req),
    .host_addr_i  ({a2, a1, a0}),
    .host_we_i    (we),
    .host_be_i    (HOST_BE),
    .host_wdata_i ({WDATA2, WDATA1, WDATA0}),
    .host_gnt_o   (fx_gnt),
    .host_rvalid_o(fx_rvalid),
    .host_err_o   (fx_err),
    .host_rdata_o (fx_rdata),
    .dev_req_o    (fx_dreq),
    .dev_addr_o   (fx_daddr),
    .dev_we_o     (fx_dwe),
    .dev_be_o     (fx_dbe),
    .dev_wdata_o  (fx_dwdata),
    .dev_rdata_i  (64'h0)
  );

  // Device models with one-cycle read latency: device 0 is a small SRAM-like
  // pattern (0x10 holds 0xCAFEF00D), device 1 echoes its address offset.
  always @(posedge clk) begin
    if (rr_dreq[0]) rd0_q <= (rr_daddr == 32'h10) ? 32'hCAFEF00D : {16'hD0D0, rr_daddr[15:0]};
    if (rr_dreq[1]) rd1_q <= {16'hB1B1, rr_daddr[15:0]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_wdata(input logic [2:0] g);
    case (g)
      3'b001:  return WDATA0;
      3'b010:  return WDATA1;
      3'b100:  return WDATA2;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] g);
    case (g)
      3'b001:  return 4'h1;
      3'b010:  return 4'h2;
      3'b100:  return 4'h4;
      default: return 4'h0;
    endcase
  endfunction

  // One row = one cycle. gnt/fgnt/dreq/daddr/dwe describe this cycle's grant;
  // rv/err/rdata describe the response to the previous row's grant.
  typedef struct {
    logic [2:0]  req;
    logic [2:0]  we;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [2:0]  gnt;
    logic [2:0]  fgnt;
    logic [1:0]  dreq;
    logic [31:0] daddr;
    logic        dwe;
    logic [2:0]  rv;
    logic [2:0]  err;
    logic [31:0] rdata;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  initial begin
    for (int i = 0; i < 5; i++)
      vecs[i] = '{3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 2'b00, 32'h0, 1'b0, 3'b000, 3'b000, 32'h0};
    vecs[5]  = '{3'b010, 3'b000, 32'h0, 32'h10, 32'h0, 3'b010, 3'b010, 2'b01, 32'h10, 1'b0, 3'b000, 3'b000, 32'h0};
    vecs[6]  = '{3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 2'b00, 32'h0, 1'b0, 3'b010, 3'b000, 32'hCAFEF00D};
    vecs[7]  = '{3'b111, 3'b000, 32'h1a110004, 32'h20, 32'h1a110008, 3'b100, 3'b001, 2'b10, 32'h1a110008, 1'b0, 3'b000, 3'b000, 32'h0};
    vecs[8]  = '{3'b111, 3'b000, 32'h1a110004, 32'h20, 32'h1a110008, 3'b001, 3'b001, 2'b10, 32'h1a110004, 1'b0, 3'b100, 3'b000, 32'hB1B10008};
    vecs[9]  = '{3'b111, 3'b000, 32'h1a110004, 32'h20, 32'h1a110008, 3'b010, 3'b001, 2'b01, 32'h20, 1'b0, 3'b001, 3'b000, 32'hB1B10004};
    vecs[10] = '{3'b111, 3'b000, 32'h1a110004, 32'h20, 32'h1a110008, 3'b100, 3'b001, 2'b10, 32'h1a110008, 1'b0, 3'b010, 3'b000, 32'hD0D00020};
    vecs[11] = '{3'b111, 3'b000, 32'h1a110004, 32'h20, 32'h1a110008, 3'b001, 3'b001, 2'b10, 32'h1a110004, 1'b0, 3'b100, 3'b000, 32'hB1B10008};
    vecs[12] = '{3'b111, 3'b000, 32'h1a110004, 32'h20, 32'h1a110008, 3'b010, 3'b001, 2'b01, 32'h20, 1'b0, 3'b001, 3'b000, 32'hB1B10004};
    vecs[13] = '{3'b101, 3'b000, 32'h1a110004, 32'h20, 32'h1a110008, 3'b100, 3'b001, 2'b10, 32'h1a110008, 1'b0, 3'b010, 3'b000, 32'hD0D00020};
    vecs[14] = '{3'b110, 3'b000, 32'h1a110004, 32'h20, 32'h1a110008, 3'b010, 3'b010, 2'b01, 32'h20, 1'b0, 3'b100, 3'b000, 32'hB1B10008};
    vecs[15] = '{3'b100, 3'b100, 32'h0, 32'h0, 32'h80000000, 3'b100, 3'b100, 2'b00, 32'h80000000, 1'b1, 3'b010, 3'b000, 32'hD0D00020};
    vecs[16] = '{3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 2'b00, 32'h0, 1'b0, 3'b100, 3'b100, 32'h0};
    vecs[17] = '{3'b001, 3'b000, 32'h0000FFFC, 32'h0, 32'h0, 3'b001, 3'b001, 2'b01, 32'h0000FFFC, 1'b0, 3'b000, 3'b000, 32'h0};
    vecs[18] = '{3'b001, 3'b000, 32'h00010000, 32'h0, 32'h0, 3'b001, 3'b001, 2'b00, 32'h00010000, 1'b0, 3'b001, 3'b000, 32'hD0D0FFFC};
    vecs[19] = '{3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 2'b00, 32'h0, 1'b0, 3'b001, 3'b001, 32'h0};
    vecs[20] = '{3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 2'b00, 32'h0, 1'b0, 3'b000, 3'b000, 32'h0};

    rst_n = 1'b0;
    req = '0; we = '0; a0 = '0; a1 = '0; a2 = '0;
    rd0_q = '0; rd1_q = '0;

    // Outputs while reset is held
    #1;
    chk("reset_rvalid", {29'h0, rr_rvalid}, 32'h0);
    chk("reset_err",    {29'h0, rr_err},    32'h0);
    chk("reset_rdata",  rr_rdata,           32'h0);
    chk("reset_dreq",   {30'h0, rr_dreq},   32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven cycles
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      req = vecs[i].req; we = vecs[i].we;
      a0 = vecs[i].a0; a1 = vecs[i].a1; a2 = vecs[i].a2;
      @(negedge clk);
      $display("row %0d req=%b gnt=%b fgnt=%b dreq=%b daddr=%h rvalid=%b err=%b rdata=%h",
               i, req, rr_gnt, fx_gnt, rr_dreq, rr_daddr, rr_rvalid, rr_err, rr_rdata);
      chk($sformatf("row%0d_gnt", i),    {29'h0, rr_gnt},    {29'h0, vecs[i].gnt});
      chk($sformatf("row%0d_fgnt", i),   {29'h0, fx_gnt},    {29'h0, vecs[i].fgnt});
      chk($sformatf("row%0d_dreq", i),   {30'h0, rr_dreq},   {30'h0, vecs[i].dreq});
      chk($sformatf("row%0d_daddr", i),  rr_daddr,           vecs[i].daddr);
      chk($sformatf("row%0d_dwe", i),    {31'h0, rr_dwe},    {31'h0, vecs[i].dwe});
      chk($sformatf("row%0d_dbe", i),    {28'h0, rr_dbe},    {28'h0, exp_be(vecs[i].gnt)});
      chk($sformatf("row%0d_dwdata", i), rr_dwdata,          exp_wdata(vecs[i].gnt));
      chk($sformatf("row%0d_rvalid", i), {29'h0, rr_rvalid}, {29'h0, vecs[i].rv});
      chk($sformatf("row%0d_err", i),    {29'h0, rr_err},    {29'h0, vecs[i].err});
      if (vecs[i].rv != 3'b000)
        chk($sformatf("row%0d_rdata", i), rr_rdata, vecs[i].rdata);
    end

    // Reset while a response is in flight; pointer currently at host 0
    @(posedge clk);
    #1;
    req = 3'b001; a0 = 32'h1a110004;
    @(negedge clk);
    $display("rstseq grant gnt=%b dreq=%b", rr_gnt, rr_dreq);
    chk("rstseq_gnt",  {29'h0, rr_gnt},  32'h1);
    chk("rstseq_dreq", {30'h0, rr_dreq}, 32'h2);
    @(posedge clk);
    #1;
    req = 3'b000;
    chk("rstseq_rvalid_pending", {29'h0, rr_rvalid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    $display("rstseq reset asserted rvalid=%b rdata=%h", rr_rvalid, rr_rdata);
    chk("rstseq_rvalid_cleared", {29'h0, rr_rvalid}, 32'h0);
    chk("rstseq_rdata_cleared",  rr_rdata,           32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rstseq_no_rvalid_after_release", {29'h0, rr_rvalid}, 32'h0);
    req = 3'b111; a0 = 32'h0; a1 = 32'h4; a2 = 32'h8;
    #1;
    $display("rstseq after release gnt=%b", rr_gnt);
    chk("rstseq_first_gnt", {29'h0, rr_gnt}, 32'h1);
    @(posedge clk);
    #1;
    req = 3'b000;
    chk("rstseq_rvalid_new", {29'h0, rr_rvalid}, 32'h1);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
